// File: rtl/sdram_burst_initiator.sv
// Splits 1..16-word bursts into lo/hi 16-bit SDRAM accesses; each access waits on SDRAM_done, aborting after TIMEOUT cycles.
// Read words and strobes are registered (one cycle after REL_HI); write data is pulled one word per WDATA visit via wr_ready.
module sdram_burst_initiator #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        start,
    input  logic        rw,
    input  logic [21:0] base_addr,
    input  logic [3:0]  len,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        xfer_done,
    output logic        xfer_err,
    input  logic        SDRAM_ready,
    output logic        SDRAM_as,
    output logic        SDRAM_rw,
    output logic [22:0] SDRAM_addr,
    output logic [15:0] SDRAM_data_write,
    input  logic [15:0] SDRAM_data_read,
    input  logic        SDRAM_done
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        WDATA,
        ISSUE_LO,
        REL_LO,
        ISSUE_HI,
        REL_HI
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_rw;
    logic [21:0] r_cur_addr;
    logic [3:0]  r_remaining;
    logic [31:0] r_word;
    logic [TW-1:0] r_tmo;
    logic        r_rd_valid;
    logic [31:0] r_rd_data;
    logic        r_xfer_done;
    logic        r_xfer_err;
    logic        w_tmo_hit;
    logic        w_enter_issue;

    // done in the same cycle as the last timeout count takes priority
    assign w_tmo_hit     = (r_tmo == TW'(TIMEOUT - 1)) && !SDRAM_done;
    assign w_enter_issue = ((w_next == ISSUE_LO) || (w_next == ISSUE_HI)) && (w_next != r_state);

    assign busy      = (r_state != IDLE);
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign xfer_done = r_xfer_done;
    assign xfer_err  = r_xfer_err;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        wr_ready         = 1'b0;
        SDRAM_as         = 1'b0;
        SDRAM_rw         = 1'b0;
        SDRAM_addr       = 23'd0;
        SDRAM_data_write = 16'd0;
        case (r_state)
            IDLE: begin
                if (start) w_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (SDRAM_ready && !SDRAM_done) w_next = r_rw ? WDATA : ISSUE_LO;
            end
            WDATA: begin
                wr_ready = 1'b1;
                if (wr_valid) w_next = ISSUE_LO;
            end
            ISSUE_LO: begin
                SDRAM_as         = 1'b1;
                SDRAM_rw         = r_rw;
                SDRAM_addr       = {r_cur_addr, 1'b0};
                SDRAM_data_write = r_word[15:0];
                if (SDRAM_done)     w_next = REL_LO;
                else if (w_tmo_hit) w_next = IDLE;
            end
            REL_LO: begin
                if (!SDRAM_done) w_next = ISSUE_HI;
            end
            ISSUE_HI: begin
                SDRAM_as         = 1'b1;
                SDRAM_rw         = r_rw;
                SDRAM_addr       = {r_cur_addr, 1'b1};
                SDRAM_data_write = r_word[31:16];
                if (SDRAM_done)     w_next = REL_HI;
                else if (w_tmo_hit) w_next = IDLE;
            end
            REL_HI: begin
                if (!SDRAM_done) w_next = (r_remaining == 4'd0) ? IDLE : WAIT_RDY;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_rw        <= 1'b0;
            r_cur_addr  <= 22'd0;
            r_remaining <= 4'd0;
            r_word      <= 32'd0;
            r_tmo       <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 32'd0;
            r_xfer_done <= 1'b0;
            r_xfer_err  <= 1'b0;
        end else begin
            r_rd_valid  <= 1'b0;
            r_xfer_done <= 1'b0;
            r_xfer_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rw        <= rw;
                        r_cur_addr  <= base_addr;
                        r_remaining <= len;
                    end
                end
                WDATA: begin
                    if (wr_valid) r_word <= wr_data;
                end
                ISSUE_LO, ISSUE_HI: begin
                    if (SDRAM_done) begin
                        if (!r_rw && (r_state == ISSUE_LO)) r_word[15:0]  <= SDRAM_data_read;
                        if (!r_rw && (r_state == ISSUE_HI)) r_word[31:16] <= SDRAM_data_read;
                    end else if (w_tmo_hit) begin
                        r_xfer_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                REL_HI: begin
                    if (!SDRAM_done) begin
                        if (!r_rw) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= r_word;
                        end
                        if (r_remaining == 4'd0) begin
                            r_xfer_done <= 1'b1;
                        end else begin
                            r_cur_addr  <= r_cur_addr + 22'd1;
                            r_remaining <= r_remaining - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (w_enter_issue) r_tmo <= '0;
        end
    end

endmodule

// File: doc/sdram_burst_initiator.md
SDRAM_BURST_INITIATOR -- requirements
Module: sdram_burst_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles SDRAM_as may stay high awaiting SDRAM_done before abort.
REQ-002 clk  input  1  sole clock; all logic on posedge clk.
REQ-003 rst_l  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  burst request; sampled only in IDLE.
REQ-005 rw  input  1  burst direction; 1 = write to SDRAM, 0 = read.
REQ-006 base_addr  input  22  starting 32-bit word address.
REQ-007 len  input  4  burst length minus one (1..16 words).
REQ-008 wr_valid  input  1  write word available.
REQ-009 wr_data  input  32  write word.
REQ-010 wr_ready  output  1  initiator accepts wr_data this cycle.
REQ-011 rd_valid  output  1  one-cycle strobe; rd_data holds a complete read word.
REQ-012 rd_data  output  32  assembled read word {hi16, lo16}.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 xfer_done  output  1  one-cycle strobe on successful burst completion.
REQ-015 xfer_err  output  1  one-cycle strobe on timeout abort.
REQ-016 SDRAM_ready  input  1  SDRAM responder ready for a new access.
REQ-017 SDRAM_as  output  1  access strobe to the responder.
REQ-018 SDRAM_rw  output  1  access direction; 1 = write.
REQ-019 SDRAM_addr  output  23  half-word address.
REQ-020 SDRAM_data_write  output  16  write half-word.
REQ-021 SDRAM_data_read  input  16  read half-word; valid when SDRAM_done is high.
REQ-022 SDRAM_done  input  1  access complete; stays high until the cycle after SDRAM_as falls.

Function
REQ-023 States SHALL be IDLE, WAIT_RDY, WDATA, ISSUE_LO, REL_LO, ISSUE_HI, REL_HI.
REQ-024 IDLE: on start=1, latch rw, base_addr into cur_addr, and len into remaining; go to WAIT_RDY. start in any other state is ignored.
REQ-025 WAIT_RDY: when SDRAM_ready=1 and SDRAM_done=0, go to WDATA if writing, else to ISSUE_LO.
REQ-026 WDATA: wr_ready=1 (combinational, this state only); on wr_valid=1, latch wr_data; go to ISSUE_LO.
REQ-027 ISSUE_LO: SDRAM_as=1; SDRAM_addr={cur_addr,1'b0}; SDRAM_data_write=word[15:0]; SDRAM_rw=latched rw.
- On SDRAM_done=1: if reading, capture SDRAM_data_read into the low half; go to REL_LO.
REQ-028 ISSUE_HI: same as ISSUE_LO with SDRAM_addr={cur_addr,1'b1} and word[31:16]/high half; on SDRAM_done=1 go to REL_HI.
REQ-029 SDRAM_addr, SDRAM_rw and SDRAM_data_write SHALL be stable for every cycle SDRAM_as=1.
REQ-030 REL_LO: SDRAM_as=0; when SDRAM_done=0, go to ISSUE_HI.
REQ-031 REL_HI: SDRAM_as=0; when SDRAM_done=0:
- if reading, rd_valid=1 for the next cycle, with rd_data updated that same edge;
- if remaining=0, xfer_done=1 for the next cycle and go to IDLE;
- else cur_addr+=1 (mod 2^22), remaining-=1, go to WAIT_RDY.
REQ-032 SDRAM_as SHALL never rise while SDRAM_done=1, and SHALL be low for at least one cycle between consecutive accesses.
REQ-033 A timeout counter SHALL clear on entry to ISSUE_LO/ISSUE_HI and increment each cycle there without SDRAM_done.
- On reaching TIMEOUT: drop SDRAM_as, pulse xfer_err next cycle, go to IDLE.
- No rd_valid or xfer_done for the aborted word.
REQ-034 SDRAM_done and timeout in the same cycle: done wins.
REQ-035 cur_addr wrap from 22'h3FFFFF to 0 SHALL occur silently mid-burst.
REQ-036 Write data SHALL be pulled one word per WDATA visit (exactly len+1 handshakes per write burst); wr_valid outside WDATA is ignored.
REQ-037 rd_valid, xfer_done and xfer_err SHALL be registered outputs.

Reset
REQ-038 On rst_l=0 at posedge clk: state=IDLE; SDRAM_as=0, SDRAM_rw=0, SDRAM_addr=0, SDRAM_data_write=0, rd_valid=0, rd_data=0, busy=0, xfer_done=0, xfer_err=0, wr_ready=0; counters cleared.
REQ-039 Reset mid-burst SHALL abandon the burst with no done/err strobe; SDRAM_as is low the cycle after reset is sampled.

Verification
REQ-040 Write burst, base_addr=5, len=1, words 32'hAAAA5555 and 32'h12345678, responder with 4-cycle latency -> half-words 5555@10, AAAA@11, 5678@12, 1234@13; exactly 2 wr_ready handshakes; one xfer_done.
REQ-041 Read-back of the same range -> rd_valid twice, rd_data=32'hAAAA5555 then 32'h12345678; xfer_done coincides with the second rd_valid.
REQ-042 Responder never asserts done, TIMEOUT=8 -> SDRAM_as high exactly 8 cycles, then xfer_err pulse, busy=0, no rd_valid.
REQ-043 base_addr=22'h3FFFFF, len=1, read -> SDRAM_addr sequence 7FFFFE, 7FFFFF, 000000, 000001.
REQ-044 SDRAM_ready held low 20 cycles after start -> SDRAM_as stays 0 until ready rises; start pulsed while busy is ignored.
REQ-045 rst_l low during ISSUE_HI -> next cycle SDRAM_as=0, busy=0, no strobes; a new burst afterwards completes normally.
